// File: rtl/global_avg_pool_64ch_8x8.sv
// Global average pool: reads CH x HW 4-bit upstream maps and stores one rounded 4-bit mean per channel.
// Latency: done pulses CH*HW + RD_LAT + 1 cycles after up_done is sampled; read_data lags read_addr by one cycle.
// Backpressure: none; upstream is read at one address per cycle and start is ignored while busy.
module global_avg_pool_64ch_8x8 #(
    parameter int CH     = 64,
    parameter int HW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [31:0] read_addr,
    output logic [3:0]  read_data,
    output logic        up_start,
    input  logic        up_done,
    output logic [31:0] up_read_addr,
    input  logic [3:0]  up_read_data
);

    localparam int CH_W  = $clog2(CH);
    localparam int PIX_W = $clog2(HW);
    localparam int ACC_W = 4 + PIX_W;
    localparam int N_EL  = CH * HW;

    localparam logic [31:0]      LAST_ADDR = 32'(N_EL - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(HW - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CH - 1);
    localparam logic [ACC_W:0]   ROUND     = (ACC_W + 1)'(HW / 2);

    typedef enum logic [2:0] {
        IDLE,
        UP_START,
        UP_WAIT,
        ACCUM,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]        rst_sync;
    logic              start_ok;
    logic              e0;
    logic              issue_vld;
    logic [RD_LAT-1:0] vld_sr;
    logic              acc_take;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W:0]    acc_rnd;
    logic [3:0]        avg;
    logic [PIX_W-1:0]  pix_cnt;
    logic [CH_W-1:0]   ch_cnt;
    logic              acc_fin;
    logic [3:0]        result [CH];

    // Reset release is shifted through two flops; start is only honoured once both are set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign start_ok = rst_sync[1];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        up_start  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && start_ok) begin
                    state_nxt = UP_START;
                end
            end
            UP_START: begin
                up_start  = 1'b1;
                state_nxt = UP_WAIT;
            end
            UP_WAIT: begin
                if (up_done) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (acc_fin) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // The edge where up_done is seen in UP_WAIT starts the read sweep.
    assign e0 = (state == UP_WAIT) && up_done;

    // Address generator: one address per cycle, holds the last address once the sweep ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            up_read_addr <= 32'd0;
            issue_vld    <= 1'b0;
        end else if (e0) begin
            up_read_addr <= 32'd0;
            issue_vld    <= 1'b1;
        end else if ((state == ACCUM) && issue_vld) begin
            if (up_read_addr == LAST_ADDR) begin
                issue_vld <= 1'b0;
            end else begin
                up_read_addr <= up_read_addr + 32'd1;
            end
        end
    end

    // Valid pipeline matching the upstream read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_sr <= '0;
        end else if (e0) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign acc_take = vld_sr[RD_LAT-1] && (state == ACCUM);
    assign acc_sum  = acc + ACC_W'(up_read_data);
    assign acc_rnd  = {1'b0, acc_sum} + ROUND;
    // Max sum 15*HW plus HW/2 still rounds to at most 15, so no saturation.
    assign avg      = 4'(acc_rnd >> PIX_W);

    // Per-channel accumulation; the last pixel writes the rounded mean and restarts the sum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc     <= '0;
            pix_cnt <= '0;
            ch_cnt  <= '0;
            acc_fin <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                result[i] <= 4'd0;
            end
        end else if (e0) begin
            acc     <= '0;
            pix_cnt <= '0;
            ch_cnt  <= '0;
            acc_fin <= 1'b0;
        end else if (acc_take) begin
            if (pix_cnt == LAST_PIX) begin
                result[ch_cnt] <= avg;
                acc            <= '0;
                pix_cnt        <= '0;
                ch_cnt         <= ch_cnt + CH_W'(1);
                if (ch_cnt == LAST_CH) begin
                    acc_fin <= 1'b1;
                end
            end else begin
                acc     <= acc_sum;
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

    // Registered result read port; out-of-range indices read as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            read_data <= 4'd0;
        end else if (read_addr < 32'(CH)) begin
            read_data <= result[read_addr[CH_W-1:0]];
        end else begin
            read_data <= 4'd0;
        end
    end

endmodule

// File: tb/tb_global_avg_pool_64ch_8x8.sv
module tb_global_avg_pool_64ch_8x8;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   passes = 0;
    int   checks = 0;
    int   mode_a = 0;
    int   mode_b = 4;

    logic        a_start, a_busy, a_done, a_ups, a_upd;
    logic [31:0] a_ra, a_ura;
    logic [3:0]  a_rd, a_urd;

    logic        b_start, b_busy, b_done, b_ups, b_upd;
    logic [31:0] b_ra, b_ura;
    logic [3:0]  b_rd, b_urd, b_p1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    global_avg_pool_64ch_8x8 #(.CH(64), .HW(64), .RD_LAT(1)) dut_a (
        .clk(clk), .resetn(resetn), .start(a_start), .busy(a_busy), .done(a_done),
        .read_addr(a_ra), .read_data(a_rd), .up_start(a_ups), .up_done(a_upd),
        .up_read_addr(a_ura), .up_read_data(a_urd)
    );

    global_avg_pool_64ch_8x8 #(.CH(64), .HW(64), .RD_LAT(2)) dut_b (
        .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .done(b_done),
        .read_addr(b_ra), .read_data(b_rd), .up_start(b_ups), .up_done(b_upd),
        .up_read_addr(b_ura), .up_read_data(b_urd)
    );

    // Upstream map contents per scenario.
    function automatic logic [3:0] elem(input int m, input logic [31:0] a);
        int c;
        int p;
        logic [3:0] r;
        c = int'(a / 64);
        p = int'(a % 64);
        r = 4'd0;
        case (m)
            0: r = 4'd7;
            1: r = 4'(c % 16);
            2: begin
                if (c == 5)      r = (p < 32) ? 4'd1 : 4'd0;
                else if (c == 6) r = (p < 31) ? 4'd1 : 4'd0;
                else if (c == 9) r = 4'd15;
            end
            3: r = 4'd3;
            4: r = 4'd4;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // Upstream memories with 1- and 2-cycle read latency.
    always @(posedge clk) begin
        a_urd <= elem(mode_a, a_ura);
        b_p1  <= elem(mode_b, b_ura);
        b_urd <= b_p1;
    end

    task automatic rd_a(input logic [31:0] addr, output logic [3:0] d);
        @(negedge clk) a_ra = addr;
        @(negedge clk) d = a_rd;
    endtask

    task automatic rd_b(input logic [31:0] addr, output logic [3:0] d);
        @(negedge clk) b_ra = addr;
        @(negedge clk) d = b_rd;
    endtask

    // Start DUT A, answer its up_start with an up_done pulse; e0 = edge count where up_done was sampled.
    task automatic kick_a(input bit start_in_wait, output int e0, output bit ok);
        ok = 1'b0;
        e0 = cyc;
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_ups) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        @(negedge clk) a_start = start_in_wait;
        @(negedge clk) a_start = 1'b0;
        @(negedge clk) a_upd = 1'b1;
        @(negedge clk) e0 = cyc;
        a_upd = 1'b0;
    endtask

    task automatic run_a(input int e0, input bit start_in_accum,
                         output int lat, output int ndone, output int nups);
        int k;
        lat = -1;
        ndone = 0;
        nups = 0;
        for (int i = 0; i < 6000; i++) begin
            k = cyc - e0;
            a_start = start_in_accum && (k == 100);
            if (a_ups) nups++;
            if (a_done) begin
                ndone++;
                lat = k;
            end
            if (!a_busy) break;
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", a_busy); else passes++;
        checks++; if (a_done !== 1'b0) $display("FAIL rst_done got %b want 0", a_done); else passes++;
        checks++; if (a_ups !== 1'b0) $display("FAIL rst_up_start got %b want 0", a_ups); else passes++;
        checks++; if (a_ura !== 32'd0) $display("FAIL rst_up_addr got %0d want 0", a_ura); else passes++;
        checks++; if (a_rd !== 4'd0) $display("FAIL rst_read_data got %0d want 0", a_rd); else passes++;
        // start on the first edge after release must be ignored
        @(negedge clk);
        resetn = 1'b1;
        a_start = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) $display("FAIL rst_sync_start got busy %b want 0", a_busy); else passes++;
        checks++; if (b_busy !== 1'b0) $display("FAIL rst_sync_start_b got busy %b want 0", b_busy); else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_const_map();
        int e0, lat, nd, nu;
        bit ok;
        logic [3:0] d;
        mode_a = 0;
        kick_a(1'b0, e0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL const_up_start got %b want 1", ok); else passes++;
        run_a(e0, 1'b0, lat, nd, nu);
        checks++; if (lat !== 4098) $display("FAIL const_done_lat got %0d want 4098", lat); else passes++;
        checks++; if (nd !== 1) $display("FAIL const_done_count got %0d want 1", nd); else passes++;
        for (int c = 0; c < 64; c++) begin
            rd_a(32'(c), d);
            checks++; if (d !== 4'd7) $display("FAIL const_read ch %0d got %0d want 7", c, d); else passes++;
        end
    endtask

    task automatic test_ramp();
        int e0, lat, nd, nu;
        bit ok;
        logic [3:0] d;
        mode_a = 1;
        kick_a(1'b0, e0, ok);
        run_a(e0, 1'b0, lat, nd, nu);
        checks++; if (lat !== 4098) $display("FAIL ramp_done_lat got %0d want 4098", lat); else passes++;
        for (int c = 0; c < 64; c++) begin
            rd_a(32'(c), d);
            checks++; if (d !== 4'(c % 16)) $display("FAIL ramp_read ch %0d got %0d want %0d", c, d, c % 16); else passes++;
        end
    endtask

    task automatic test_rounding();
        int e0, lat, nd, nu;
        bit ok;
        logic [3:0] d;
        mode_a = 2;
        kick_a(1'b0, e0, ok);
        run_a(e0, 1'b0, lat, nd, nu);
        rd_a(32'd5, d);
        checks++; if (d !== 4'd1) $display("FAIL round_half_up got %0d want 1", d); else passes++;
        rd_a(32'd6, d);
        checks++; if (d !== 4'd0) $display("FAIL round_below_half got %0d want 0", d); else passes++;
        rd_a(32'd9, d);
        checks++; if (d !== 4'd15) $display("FAIL round_max got %0d want 15", d); else passes++;
        rd_a(32'd4, d);
        checks++; if (d !== 4'd0) $display("FAIL round_zero_ch got %0d want 0", d); else passes++;
    endtask

    task automatic test_handshake();
        int e0, lat, nd, nu, act;
        bit ok;
        mode_a = 0;
        kick_a(1'b1, e0, ok);
        run_a(e0, 1'b1, lat, nd, nu);
        checks++; if (nu !== 0) $display("FAIL hs_extra_up_start got %0d want 0", nu); else passes++;
        checks++; if (nd !== 1) $display("FAIL hs_done_count got %0d want 1", nd); else passes++;
        checks++; if (lat !== 4098) $display("FAIL hs_done_lat got %0d want 4098", lat); else passes++;
        act = 0;
        @(negedge clk) a_upd = 1'b1;
        @(negedge clk) a_upd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (a_busy || a_ups || a_done) act++;
            @(negedge clk);
        end
        checks++; if (act !== 0) $display("FAIL hs_idle_up_done got %0d active cycles want 0", act); else passes++;
        checks++; if (a_ura !== 32'd4095) $display("FAIL hs_addr_hold got %0d want 4095", a_ura); else passes++;
    endtask

    task automatic test_reset_mid_accum();
        int e0, lat, nd, nu;
        bit ok;
        logic [3:0] d;
        mode_a = 0;
        kick_a(1'b0, e0, ok);
        for (int i = 0; i < 3000; i++) begin
            if (cyc - e0 >= 2000) break;
            @(negedge clk);
        end
        checks++; if (a_ura !== 32'd2000) $display("FAIL abort_at_pixel got %0d want 2000", a_ura); else passes++;
        resetn = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", a_busy); else passes++;
        @(negedge clk) resetn = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_done) nd++;
            @(negedge clk);
        end
        checks++; if (nd !== 0) $display("FAIL abort_done got %0d pulses want 0", nd); else passes++;
        for (int c = 0; c < 64; c++) begin
            rd_a(32'(c), d);
            checks++; if (d !== 4'd0) $display("FAIL abort_read ch %0d got %0d want 0", c, d); else passes++;
        end
        mode_a = 3;
        kick_a(1'b0, e0, ok);
        run_a(e0, 1'b0, lat, nd, nu);
        checks++; if (lat !== 4098) $display("FAIL restart_done_lat got %0d want 4098", lat); else passes++;
        for (int c = 0; c < 64; c++) begin
            rd_a(32'(c), d);
            checks++; if (d !== 4'd3) $display("FAIL restart_read ch %0d got %0d want 3", c, d); else passes++;
        end
        rd_a(32'd64, d);
        checks++; if (d !== 4'd0) $display("FAIL oob_64 got %0d want 0", d); else passes++;
        rd_a(32'hFFFF_FFFF, d);
        checks++; if (d !== 4'd0) $display("FAIL oob_max got %0d want 0", d); else passes++;
    endtask

    task automatic test_rdlat2();
        int e0, k, lat, nd, nmatch, bad;
        bit ok;
        logic [3:0] d;
        mode_b = 4;
        ok = 1'b0;
        e0 = cyc;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b_ups) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (ok !== 1'b1) $display("FAIL lat2_up_start got %b want 1", ok); else passes++;
        @(negedge clk) b_upd = 1'b1;
        @(negedge clk) e0 = cyc;
        b_upd = 1'b0;
        lat = -1;
        nd = 0;
        nmatch = 0;
        bad = 0;
        for (int i = 0; i < 6000; i++) begin
            k = cyc - e0;
            if (k < 4096) begin
                if (b_ura === 32'(k)) nmatch++;
                else bad++;
            end else if (b_ura !== 32'd4095) begin
                bad++;
            end
            if (b_done) begin
                nd++;
                lat = k;
            end
            if (!b_busy) break;
            @(negedge clk);
        end
        checks++; if (lat !== 4099) $display("FAIL lat2_done_lat got %0d want 4099", lat); else passes++;
        checks++; if (nd !== 1) $display("FAIL lat2_done_count got %0d want 1", nd); else passes++;
        checks++; if (nmatch !== 4096) $display("FAIL lat2_addr_count got %0d want 4096", nmatch); else passes++;
        checks++; if (bad !== 0) $display("FAIL lat2_addr_order got %0d bad cycles want 0", bad); else passes++;
        for (int c = 0; c < 64; c++) begin
            rd_b(32'(c), d);
            checks++; if (d !== 4'd4) $display("FAIL lat2_read ch %0d got %0d want 4", c, d); else passes++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        resetn  = 1'b0;
        a_start = 1'b0; a_upd = 1'b0; a_ra = 32'd0;
        b_start = 1'b0; b_upd = 1'b0; b_ra = 32'd0;
        test_reset();
        test_const_map();
        test_ramp();
        test_rounding();
        test_handshake();
        test_reset_mid_accum();
        test_rdlat2();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
